// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the Wishbone slave memory
package wb_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } wb_state_e;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 8;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wb_bytelane_ram.sv
// rtl/wb_bytelane_ram.sv - single-port RAM with per-byte write enables and registered read
module wb_bytelane_ram
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Read register only moves on a read, so it holds the last successful read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_slv_mem.sv
// rtl/wb_slv_mem.sv - Wishbone classic slave RAM with wait states, abort, range error and post-reset clear
module wb_slv_mem
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int                LANES     = lane_count(DATA_W);
  localparam int                RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [RAM_AW-1:0] LAST_WORD = RAM_AW'(DEPTH - 1);
  localparam logic [3:0]        WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e             state_q, state_d;
  logic [RAM_AW-1:0]     cnt_q, cnt_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [LANES-1:0]      sel_q, sel_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  req;
  logic                  complete;
  logic                  in_range;
  logic [ADDR_W-1:0]     cur_addr;
  logic                  cur_we;
  logic [LANES-1:0]      cur_sel;
  logic [DATA_W-1:0]     cur_wdata;

  logic                  ram_we;
  logic                  ram_re;
  logic [LANES-1:0]      ram_be;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;

  assign req = cyc & stb;

  // With zero wait states the access completes on the sampling edge, so use the live bus.
  assign cur_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign cur_we    = (state_q == IDLE) ? we    : we_q;
  assign cur_sel   = (state_q == IDLE) ? sel   : sel_q;
  assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;
  assign in_range  = {1'b0, cur_addr} < DEPTH_L;

  always_comb begin
    complete = 1'b0;
    case (state_q)
      IDLE:    complete = req && (WAIT_STATES == 0);
      WAIT:    complete = cyc && (wcnt_q == 4'd0);
      default: complete = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: if (cnt_q == LAST_WORD) state_d = IDLE;
      IDLE: begin
        if (req) state_d = (WAIT_STATES == 0) ? ACK : WAIT;
      end
      WAIT: begin
        if (!cyc) begin
          state_d = IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The clear sweep shares the single RAM port; bus accesses never overlap it.
  always_comb begin
    busy      = (state_q == INIT);
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state_q == INIT) begin
      ram_we   = 1'b1;
      ram_be   = '1;
      ram_addr = cnt_q;
    end else if (complete && in_range) begin
      ram_addr = cur_addr[RAM_AW-1:0];
      if (cur_we) begin
        ram_we    = 1'b1;
        ram_be    = cur_sel;
        ram_wdata = cur_wdata;
      end else begin
        ram_re = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    ack_d   = complete && in_range;
    err_d   = complete && !in_range;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == IDLE && req) begin
      addr_d  = addr;
      we_d    = we;
      sel_d   = sel;
      wdata_d = wdata;
      wcnt_d  = WCNT_INIT;
    end else if (state_q == WAIT && wcnt_q != 4'd0) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack = ack_q;
  assign err = err_q;

  wb_bytelane_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_wb_slv_mem.sv
// tb/tb_wb_slv_mem.sv - scoreboard bench for wb_slv_mem (DEPTH 256 and DEPTH 200 instances)
module tb_wb_slv_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_a, cyc_b, stb, we;
  logic [3:0]  sel;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, err_a, busy_a, ack_b, err_b, busy_b;

  always #5 clk = ~clk;

  wb_slv_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst), .cyc(cyc_a), .stb(stb), .we(we), .sel(sel), .addr(addr),
    .wdata(wdata), .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
  );

  wb_slv_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(2)) dut_b (
    .clk(clk), .rst(rst), .cyc(cyc_b), .stb(stb), .we(we), .sel(sel), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] rd;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input exp_t e, input logic a, input logic r, input logic [31:0] rd);
    tests++;
    if (a !== !e.is_err || r !== e.is_err || rd !== e.rd) begin
      fails++;
      $display("FAIL %s: ack=%b err=%b rdata=%h expected ack=%b err=%b rdata=%h",
               e.name, a, r, rd, !e.is_err, e.is_err, e.rd);
    end
  endtask

  always @(negedge clk) begin
    if (ack_a || err_a) begin
      if (q_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp_a: ack=%b err=%b expected no response", ack_a, err_a);
      end else begin
        check_resp(q_a.pop_front(), ack_a, err_a, rdata_a);
      end
    end
    if (ack_b || err_b) begin
      if (q_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp_b: ack=%b err=%b expected no response", ack_b, err_b);
      end else begin
        check_resp(q_b.pop_front(), ack_b, err_b, rdata_b);
      end
    end
  end

  task automatic xfer(input bit dev_b, input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit exp_err, input logic [31:0] exp_rd,
                      input string name);
    exp_t e;
    int   lat;
    bit   done;
    e.is_err = exp_err;
    e.rd     = exp_rd;
    e.name   = name;
    if (dev_b) q_b.push_back(e);
    else       q_a.push_back(e);
    @(negedge clk);
    cyc_a = !dev_b;
    cyc_b = dev_b;
    stb   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sel   = s;
    lat   = 0;
    done  = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      done = dev_b ? (ack_b || err_b) : (ack_a || err_a);
    end
    // Sampling edge, two wait edges, then the response is visible: third falling edge.
    check({name, "_latency"}, lat, 32'd3);
    cyc_a = 1'b0;
    cyc_b = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
  endtask

  task automatic wait_clear(output int na, output int nb);
    na = 0;
    nb = 0;
    while (busy_a && na < 1000) begin
      @(posedge clk);
      #1;
      na++;
      if (!busy_b && nb == 0) nb = na;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, resp;
    rst = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; addr = 8'h00; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy_a", busy_a, 1);
    check("rst_ack_a", ack_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_busy_b", busy_b, 1);

    rst = 1'b1;
    wait_clear(na, nb);
    check("t1_busy_cycles_a", na, 256);
    check("t1_busy_cycles_b", nb, 200);

    xfer(0, 0, 8'h10, 32'h0, 4'hF, 0, 32'h00000000, "t1_rd10");
    xfer(0, 1, 8'h05, 32'hDEADBEEF, 4'hF, 0, 32'h00000000, "t2_wr05");
    xfer(0, 0, 8'h05, 32'h0, 4'hF, 0, 32'hDEADBEEF, "t2_rd05");
    xfer(0, 1, 8'h05, 32'h11223344, 4'b0101, 0, 32'hDEADBEEF, "t3_wr05_sel5");
    xfer(0, 0, 8'h05, 32'h0, 4'h0, 0, 32'hDE22BE44, "t3_rd05");

    xfer(1, 1, 8'hC7, 32'h0BADF00D, 4'hF, 0, 32'h00000000, "t4_wrC7");
    xfer(1, 0, 8'hC7, 32'h0, 4'hF, 0, 32'h0BADF00D, "t4_rdC7");
    xfer(1, 0, 8'hC8, 32'h0, 4'hF, 1, 32'h0BADF00D, "t4_rdC8_err");
    xfer(1, 1, 8'hFF, 32'h55555555, 4'hF, 1, 32'h0BADF00D, "t4_wrFF_err");
    xfer(1, 0, 8'hC7, 32'h0, 4'hF, 0, 32'h0BADF00D, "t4_rdC7_again");

    @(negedge clk);
    cyc_a = 1'b1; stb = 1'b1; we = 1'b1; addr = 8'h07; wdata = 32'hA5A5A5A5; sel = 4'hF;
    @(negedge clk);
    cyc_a = 1'b0;
    resp = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a || err_a) resp++;
    end
    stb = 1'b0; we = 1'b0;
    check("t5_abort_no_resp", resp, 0);
    xfer(0, 0, 8'h07, 32'h0, 4'hF, 0, 32'h00000000, "t5_rd07");

    xfer(0, 1, 8'h09, 32'h12345678, 4'hF, 0, 32'h00000000, "t6_wr09");
    xfer(0, 0, 8'h09, 32'h0, 4'hF, 0, 32'h12345678, "t6_rd09");
    @(negedge clk);
    cyc_a = 1'b1; stb = 1'b1; we = 1'b1; addr = 8'h09; wdata = 32'hCAFEF00D; sel = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_ack", ack_a, 0);
    check("t6_rst_busy", busy_a, 1);
    check("t6_rst_rdata", rdata_a, 0);
    cyc_a = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_clear(na, nb);
    check("t6_busy_cycles_a", na, 256);
    xfer(0, 0, 8'h09, 32'h0, 4'hF, 0, 32'h00000000, "t6_rd09_cleared");

    repeat (3) @(negedge clk);
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
